// File: rtl/cache_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types
//
// Shared type package for the memory subsystem. This file carries the pieces
// used by the cache arbiter:
//   - cache_arb_state_t : arbiter FSM states
//   - CACHE_LINE_W      : cacheline width in bits
// ----------------------------------------------------------------------------
package rv32i_types;

    localparam int CACHE_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_I    = 2'd1,
        SERVE_D_RD = 2'd2,
        SERVE_D_WR = 2'd3
    } cache_arb_state_t;

endpackage : rv32i_types

// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
//
// Shares the single cacheline-adapter port between the I-cache and D-cache.
// One requester is granted at a time; its address (and write data for a
// writeback) is captured at grant and held until the adapter's pmem_resp.
// The response pulse is steered only to the granted cache. All pmem_* outputs
// are registered, so no combinational path runs from cache requests to them.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   instr_read/instr_addr  I-cache line read request
//   instr_mem_resp         I-cache completion pulse
//   instr_cacheline        read data to I-cache (pmem_rdata passthrough)
//   data_read/data_write   D-cache read / writeback request (mutually exclusive)
//   data_addr              D-cache line address
//   data_mem_wdata         D-cache writeback data
//   data_mem_resp          D-cache completion pulse
//   data_cacheline         read data to D-cache (pmem_rdata passthrough)
//   pmem_rdata, pmem_resp  adapter read data and done pulse
//   pmem_read, pmem_write  adapter strobes (registered)
//   pmem_address           address captured at grant
//   pmem_wdata             write data captured at writeback grant
//
// Configuration:
//   CACHE_ARB_ROUND_ROBIN_EN  when defined, simultaneous I/D requests in IDLE
//                             alternate using a last-grant flop; otherwise the
//                             D-cache always wins.
// ----------------------------------------------------------------------------
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = CACHE_LINE_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_mem_resp,
    output logic [LINE_W-1:0] instr_cacheline,

    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [LINE_W-1:0] data_mem_wdata,
    output logic              data_mem_resp,
    output logic [LINE_W-1:0] data_cacheline,

    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata
);

    cache_arb_state_t state;

    logic data_req;
    logic grant_data;

    assign data_req = data_read | data_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // 1 = D-cache received the most recent grant, 0 = I-cache.
    logic last_grant_data;

    // On a tie, hand the port to whichever cache did not get it last time.
    always_comb begin
        grant_data = data_req;
        if (data_req && instr_read) begin
            grant_data = ~last_grant_data;
        end
    end
`else
    always_comb begin
        grant_data = data_req;
    end
`endif

    // Single FSM: state, strobes and captured address/data move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant_data <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (data_req || instr_read) begin
                        pmem_address <= grant_data ? data_addr : instr_addr;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                        last_grant_data <= grant_data;
`endif
                        // data_write takes precedence if both D strobes are
                        // (illegally) high together.
                        if (grant_data && data_write) begin
                            state      <= SERVE_D_WR;
                            pmem_write <= 1'b1;
                            pmem_wdata <= data_mem_wdata;
                        end else if (grant_data) begin
                            state     <= SERVE_D_RD;
                            pmem_read <= 1'b1;
                        end else begin
                            state     <= SERVE_I;
                            pmem_read <= 1'b1;
                        end
                    end
                end
                default: begin
                    // No abort path: a dropped request still runs to pmem_resp.
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Response steering: only the granted cache sees the done pulse; a
    // pmem_resp arriving while IDLE reaches nobody.
    assign instr_mem_resp  = pmem_resp & (state == SERVE_I);
    assign data_mem_resp   = pmem_resp & ((state == SERVE_D_RD) || (state == SERVE_D_WR));
    assign instr_cacheline = pmem_rdata;
    assign data_cacheline  = pmem_rdata;

    a_data_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(data_read && data_write));

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_arbiter
//
// Directed scenarios followed by randomized traffic, checked against a
// transaction-level model of the arbiter (busy flag, owner, captured
// address/data). Honours CACHE_ARB_ROUND_ROBIN_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_read;
    logic [AW-1:0] instr_addr;
    logic          instr_mem_resp;
    logic [LW-1:0] instr_cacheline;
    logic          data_read;
    logic          data_write;
    logic [AW-1:0] data_addr;
    logic [LW-1:0] data_mem_wdata;
    logic          data_mem_resp;
    logic [LW-1:0] data_cacheline;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;

    always #5 clk = ~clk;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_read     (instr_read),
        .instr_addr     (instr_addr),
        .instr_mem_resp (instr_mem_resp),
        .instr_cacheline(instr_cacheline),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_addr      (data_addr),
        .data_mem_wdata (data_mem_wdata),
        .data_mem_resp  (data_mem_resp),
        .data_cacheline (data_cacheline),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: is a transaction outstanding, who owns it, what was captured.
    // m_owner: 0 = instruction read, 1 = data read, 2 = data writeback
    bit            m_busy  = 1'b0;
    int            m_owner = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;
    bit            m_prev_was_data = 1'b0;

    task automatic model_edge();
        bit d_req;
        bit pick_d;
        if (rst) begin
            m_busy          = 1'b0;
            m_addr          = '0;
            m_wdata         = '0;
            m_prev_was_data = 1'b0;
        end else if (m_busy) begin
            if (pmem_resp) m_busy = 1'b0;
        end else begin
            d_req = data_read || data_write;
            if (d_req || instr_read) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                if (d_req && instr_read) pick_d = !m_prev_was_data;
                else                     pick_d = d_req;
`else
                pick_d = d_req;
`endif
                m_prev_was_data = pick_d;
                m_busy = 1'b1;
                if (!pick_d) begin
                    m_owner = 0;
                    m_addr  = instr_addr;
                end else begin
                    m_addr = data_addr;
                    if (data_write) begin
                        m_owner = 2;
                        m_wdata = data_mem_wdata;
                    end else begin
                        m_owner = 1;
                    end
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check_eq("iresp", instr_mem_resp, pmem_resp && m_busy && (m_owner == 0));
        check_eq("dresp", data_mem_resp,  pmem_resp && m_busy && (m_owner != 0));
        check_eq("iline", instr_cacheline, pmem_rdata);
        check_eq("dline", data_cacheline,  pmem_rdata);
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rd",    pmem_read,    m_busy && (m_owner != 2));
        check_eq("wr",    pmem_write,   m_busy && (m_owner == 2));
        check_eq("addr",  pmem_address, m_addr);
        check_eq("wdata", pmem_wdata,   m_wdata);
        @(negedge clk);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_inputs();
        instr_read = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    logic [AW-1:0] exp_seq [3];
    logic [LW-1:0] a5_line;

    initial begin
        rst            = 1'b1;
        instr_read     = 1'b1;
        instr_addr     = 32'h0000_1000;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_addr      = '0;
        data_mem_wdata = '0;
        pmem_rdata     = rand_line();
        pmem_resp      = 1'b0;
        @(negedge clk);

        // Reset held with an I-cache request pending.
        cycle();
        cycle();
        check_eq("rst_addr", pmem_address, 32'h0);
        check_eq("rst_rd",   pmem_read,    1'b0);
        rst = 1'b0;
        cycle();
        check_eq("t1_rd",   pmem_read,    1'b1);
        check_eq("t1_addr", pmem_address, 32'h0000_1000);
        for (int i = 0; i < 4; i++) cycle();
        pmem_resp = 1'b1;
        #1 check_eq("t1_iresp", instr_mem_resp, 1'b1);
        check_eq("t1_dresp", data_mem_resp, 1'b0);
        cycle();
        check_eq("t1_rd_off", pmem_read, 1'b0);
        idle_inputs();
        cycle();

        // Writeback with write data changing mid-service.
        a5_line        = {32{8'hA5}};
        data_write     = 1'b1;
        data_addr      = 32'h8000_0040;
        data_mem_wdata = a5_line;
        cycle();
        check_eq("wb_wr", pmem_write, 1'b1);
        data_write     = 1'b0;
        data_mem_wdata = rand_line();
        cycle();
        cycle();
        check_eq("wb_hold", pmem_wdata, a5_line);
        pmem_resp = 1'b1;
        #1 check_eq("wb_dresp", data_mem_resp, 1'b1);
        cycle();
        idle_inputs();
        cycle();

        // Both caches reading, held over three transactions.
        do_reset();
        instr_read = 1'b1;
        instr_addr = 32'h0000_2000;
        data_read  = 1'b1;
        data_addr  = 32'h4000_0100;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 32'h4000_0100;
        exp_seq[1] = 32'h0000_2000;
        exp_seq[2] = 32'h4000_0100;
`else
        exp_seq[0] = 32'h4000_0100;
        exp_seq[1] = 32'h4000_0100;
        exp_seq[2] = 32'h4000_0100;
`endif
        for (int n = 0; n < 3; n++) begin
            cycle();
            check_eq($sformatf("both_grant%0d", n), pmem_address, exp_seq[n]);
            cycle();
            pmem_resp = 1'b1;
            cycle();
            pmem_resp = 1'b0;
        end
        idle_inputs();
        cycle();

        // I-cache drops its request right after grant.
        instr_read = 1'b1;
        instr_addr = 32'h0000_3040;
        cycle();
        instr_read = 1'b0;
        cycle();
        cycle();
        check_eq("drop_rd", pmem_read, 1'b1);
        pmem_resp = 1'b1;
        #1 check_eq("drop_iresp", instr_mem_resp, 1'b1);
        cycle();
        idle_inputs();

        // Stray pmem_resp while IDLE.
        pmem_resp = 1'b1;
        cycle();
        check_eq("stray_rd", pmem_read, 1'b0);
        pmem_resp = 1'b0;

        // Reset in the middle of a data read; a later resp is not forwarded.
        data_read = 1'b1;
        data_addr = 32'h1234_5680;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check_eq("mid_rst_rd", pmem_read, 1'b0);
        rst       = 1'b0;
        data_read = 1'b0;
        pmem_resp = 1'b1;
        #1 check_eq("mid_rst_dresp", data_mem_resp, 1'b0);
        cycle();
        idle_inputs();
        cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int dsel;
            rst            = ($urandom_range(0, 63) == 0);
            instr_read     = $urandom_range(0, 1);
            dsel           = $urandom_range(0, 3);
            data_read      = (dsel == 1);
            data_write     = (dsel == 2);
            instr_addr     = $urandom;
            data_addr      = $urandom;
            data_mem_wdata = rand_line();
            pmem_rdata     = rand_line();
            pmem_resp      = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cache_arbiter
